// File: rtl/simon_bridge_pkg.sv
// Shared types and constants for the byte-stream bridge in front of the SIMON 48/96 core.
// Holds the bridge FSM encoding and the host opcodes.
package simon_bridge_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RX_KEY,
        RX_BLK,
        KEY_REQ,
        KEY_WT,
        DAT_REQ,
        DAT_WT,
        TX
    } state_t;

    localparam logic [7:0] OP_KEY = 8'h01;
    localparam logic [7:0] OP_ENC = 8'h02;
    localparam logic [7:0] OP_DEC = 8'h03;

    // Only the opcode and payload-receiving states take host bytes.
    function automatic logic accepts_input(state_t s);
        return (s == IDLE) || (s == RX_KEY) || (s == RX_BLK);
    endfunction

endpackage

// File: rtl/simon_byte_shifter.sv
// Byte-granular shift register: parallel load, shift a byte in at the LSB end,
// or shift the MSB byte out (zero fill). The first byte shifted in ends up in the MSB.
module simon_byte_shifter #(
    parameter int NBYTES = 6
) (
    input  logic                  clk,
    input  logic                  nR,
    input  logic                  load,
    input  logic [NBYTES*8-1:0]   load_data,
    input  logic                  shift_in,
    input  logic [7:0]            byte_in,
    input  logic                  shift_out,
    output logic [NBYTES*8-1:0]   data
);

    always_ff @(posedge clk) begin
        if (!nR) begin
            data <= '0;
        end else if (load) begin
            data <= load_data;
        end else if (shift_in) begin
            data <= {data[NBYTES*8-9:0], byte_in};
        end else if (shift_out) begin
            data <= {data[NBYTES*8-9:0], 8'h00};
        end
    end

endmodule

// File: rtl/simon_byte_bridge.sv
// Host-side initiator for SIMON 48/96: assembles keys and blocks from a byte stream,
// drives the core's newKey/newData/readData handshake and streams each result back.
module simon_byte_bridge
    import simon_bridge_pkg::*;
#(
    parameter int N   = 24,
    parameter int M   = 4,
    parameter int TMO = 255
) (
    input  logic                clk,
    input  logic                nR,
    input  logic [7:0]          in_byte,
    input  logic                in_valid,
    output logic                in_ready,
    output logic [7:0]          out_byte,
    output logic                out_valid,
    input  logic                out_ready,
    output logic                busy,
    output logic                key_ok,
    output logic                err,
    output logic                newKey,
    output logic                newData,
    output logic                enc_dec,
    output logic                readData,
    output logic [M-1:0][N-1:0] KEY,
    output logic [1:0][N-1:0]   blockIN,
    input  logic                loadKey,
    input  logic                loadData,
    input  logic                doneKey,
    input  logic                doneData,
    input  logic [1:0][N-1:0]   outData
);

    localparam int BLK_B = 2 * N / 8;
    localparam int KEY_B = M * N / 8;
    localparam int CW    = $clog2(KEY_B + 1);
    localparam int TW    = $clog2(TMO + 1);

    localparam logic [CW-1:0] KEY_LAST = CW'(KEY_B - 1);
    localparam logic [CW-1:0] BLK_LAST = CW'(BLK_B - 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TMO - 1);

    state_t          state;
    state_t          state_n;
    logic [CW-1:0]   byte_cnt;
    logic [CW-1:0]   cnt_n;
    logic [TW-1:0]   tmo_cnt;
    logic [TW-1:0]   tmo_n;
    logic            key_ok_n;
    logic            enc_dec_n;
    logic            err_n;
    logic            rd_n;

    logic            in_xfer;
    logic            out_xfer;
    logic            key_shift;
    logic            blk_shift;
    logic            tx_load;
    logic            tx_shift;

    logic [KEY_B*8-1:0] key_data;
    logic [BLK_B*8-1:0] blk_data;
    logic [BLK_B*8-1:0] tx_data;
    logic [BLK_B*8-9:0] tx_unused;

    // Both byte links use valid/ready: a byte moves on a rising edge where valid and
    // ready are both 1; valid never waits on ready, and the sender holds the byte until it moves.
    assign in_ready  = nR && accepts_input(state);
    assign out_valid = (state == TX);
    assign in_xfer   = in_valid && in_ready;
    assign out_xfer  = out_valid && out_ready;
    assign busy      = (state != IDLE);

    assign KEY       = key_data;
    assign blockIN   = blk_data;
    assign out_byte  = tx_data[BLK_B*8-1 -: 8];
    assign tx_unused = tx_data[BLK_B*8-9:0];

    simon_byte_shifter #(.NBYTES(KEY_B)) u_key_sh (
        .clk       (clk),
        .nR        (nR),
        .load      (1'b0),
        .load_data ('0),
        .shift_in  (key_shift),
        .byte_in   (in_byte),
        .shift_out (1'b0),
        .data      (key_data)
    );

    simon_byte_shifter #(.NBYTES(BLK_B)) u_blk_sh (
        .clk       (clk),
        .nR        (nR),
        .load      (1'b0),
        .load_data ('0),
        .shift_in  (blk_shift),
        .byte_in   (in_byte),
        .shift_out (1'b0),
        .data      (blk_data)
    );

    simon_byte_shifter #(.NBYTES(BLK_B)) u_tx_sh (
        .clk       (clk),
        .nR        (nR),
        .load      (tx_load),
        .load_data (outData),
        .shift_in  (1'b0),
        .byte_in   (8'h00),
        .shift_out (tx_shift),
        .data      (tx_data)
    );

    always_ff @(posedge clk) begin
        if (!nR) begin
            state    <= IDLE;
            byte_cnt <= '0;
            tmo_cnt  <= '0;
            key_ok   <= 1'b0;
            enc_dec  <= 1'b1;
            err      <= 1'b0;
            readData <= 1'b0;
        end else begin
            state    <= state_n;
            byte_cnt <= cnt_n;
            tmo_cnt  <= tmo_n;
            key_ok   <= key_ok_n;
            enc_dec  <= enc_dec_n;
            err      <= err_n;
            readData <= rd_n;
        end
    end

    always_comb begin
        state_n   = state;
        cnt_n     = byte_cnt;
        tmo_n     = tmo_cnt;
        key_ok_n  = key_ok;
        enc_dec_n = enc_dec;
        err_n     = 1'b0;
        rd_n      = 1'b0;
        key_shift = 1'b0;
        blk_shift = 1'b0;
        tx_load   = 1'b0;
        tx_shift  = 1'b0;
        newKey    = 1'b0;
        newData   = 1'b0;

        case (state)
            IDLE: begin
                cnt_n = '0;
                if (in_xfer) begin
                    case (in_byte)
                        OP_KEY: begin
                            state_n  = RX_KEY;
                            key_ok_n = 1'b0;
                        end
                        OP_ENC: begin
                            state_n   = RX_BLK;
                            enc_dec_n = 1'b1;
                        end
                        OP_DEC: begin
                            state_n   = RX_BLK;
                            enc_dec_n = 1'b0;
                        end
                        default: err_n = 1'b1;
                    endcase
                end
            end

            RX_KEY: begin
                if (in_xfer) begin
                    key_shift = 1'b1;
                    if (byte_cnt == KEY_LAST) begin
                        cnt_n   = '0;
                        state_n = KEY_REQ;
                    end else begin
                        cnt_n = byte_cnt + 1'b1;
                    end
                end
            end

            RX_BLK: begin
                if (in_xfer) begin
                    blk_shift = 1'b1;
                    if (byte_cnt == BLK_LAST) begin
                        cnt_n = '0;
                        // A block with no expanded key is dropped on the floor.
                        if (key_ok) begin
                            state_n = DAT_REQ;
                        end else begin
                            state_n = IDLE;
                            err_n   = 1'b1;
                        end
                    end else begin
                        cnt_n = byte_cnt + 1'b1;
                    end
                end
            end

            KEY_REQ: begin
                if (loadKey) begin
                    newKey  = 1'b1;
                    tmo_n   = '0;
                    state_n = KEY_WT;
                end
            end

            KEY_WT: begin
                if (doneKey) begin
                    key_ok_n = 1'b1;
                    state_n  = IDLE;
                end else begin
                    tmo_n = tmo_cnt + 1'b1;
                    if (tmo_cnt == TMO_LAST) begin
                        err_n    = 1'b1;
                        key_ok_n = 1'b0;
                        state_n  = IDLE;
                    end
                end
            end

            DAT_REQ: begin
                if (loadData) begin
                    newData = 1'b1;
                    tmo_n   = '0;
                    state_n = DAT_WT;
                end
            end

            DAT_WT: begin
                if (doneData) begin
                    // readData is registered, so it lands in the first TX cycle.
                    tx_load = 1'b1;
                    rd_n    = 1'b1;
                    cnt_n   = '0;
                    state_n = TX;
                end else begin
                    tmo_n = tmo_cnt + 1'b1;
                    if (tmo_cnt == TMO_LAST) begin
                        err_n   = 1'b1;
                        state_n = IDLE;
                    end
                end
            end

            TX: begin
                if (out_xfer) begin
                    tx_shift = 1'b1;
                    if (byte_cnt == BLK_LAST) begin
                        cnt_n   = '0;
                        state_n = IDLE;
                    end else begin
                        cnt_n = byte_cnt + 1'b1;
                    end
                end
            end

            default: state_n = IDLE;
        endcase
    end

endmodule

// File: tb/tb_simon_byte_bridge.sv
// Directed bench for simon_byte_bridge with a behavioural SIMON core stub and an
// output-byte scoreboard.
module tb_simon_byte_bridge;

    localparam logic [95:0] KEY_V = 96'h1a1918121110_0a0908020100;
    localparam logic [47:0] PT_V  = 48'h72696320646e;
    localparam logic [47:0] CT_V  = 48'h6e06a5acf156;

    logic            clk;
    logic            nR;
    logic [7:0]      in_byte;
    logic            in_valid;
    logic            in_ready;
    logic [7:0]      out_byte;
    logic            out_valid;
    logic            out_ready;
    logic            busy;
    logic            key_ok;
    logic            err;
    logic            newKey;
    logic            newData;
    logic            enc_dec;
    logic            readData;
    logic [3:0][23:0] KEY;
    logic [1:0][23:0] blockIN;
    logic            loadKey;
    logic            loadData;
    logic            doneKey  = 1'b0;
    logic            doneData = 1'b0;
    logic [1:0][23:0] outData = '0;

    int checks    = 0;
    int errors    = 0;
    int cyc       = 0;
    int nkey_cnt  = 0;
    int ndata_cnt = 0;
    int nread_cnt = 0;
    int err_cnt   = 0;
    int ov_cnt    = 0;
    int out_cnt   = 0;
    int nd_cycle  = 0;
    int err_cycle = 0;
    int key_dly   = 0;
    int dat_dly   = 0;
    logic stub_hang = 1'b0;
    logic [47:0] stub_res = '0;

    logic [7:0] exp_q[$];

    simon_byte_bridge dut (
        .clk       (clk),
        .nR        (nR),
        .in_byte   (in_byte),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_byte  (out_byte),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy),
        .key_ok    (key_ok),
        .err       (err),
        .newKey    (newKey),
        .newData   (newData),
        .enc_dec   (enc_dec),
        .readData  (readData),
        .KEY       (KEY),
        .blockIN   (blockIN),
        .loadKey   (loadKey),
        .loadData  (loadData),
        .doneKey   (doneKey),
        .doneData  (doneData),
        .outData   (outData)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- core stub ----------------
    function automatic logic [47:0] core_model(input logic [47:0] blk, input logic mode);
        if (mode && blk == PT_V) return CT_V;
        if (!mode && blk == CT_V) return PT_V;
        return 48'hbad0bad0bad0;
    endfunction

    always @(negedge clk) begin
        doneKey  = 1'b0;
        doneData = 1'b0;
        if (!nR) begin
            key_dly = 0;
            dat_dly = 0;
        end else begin
            if (key_dly > 0) begin
                key_dly--;
                if (key_dly == 0) doneKey = 1'b1;
            end
            if (dat_dly > 0) begin
                dat_dly--;
                if (dat_dly == 0 && !stub_hang) begin
                    doneData = 1'b1;
                    outData  = stub_res;
                end
            end
            if (newKey) begin
                nkey_cnt++;
                key_dly = 4;
            end
            if (newData) begin
                ndata_cnt++;
                nd_cycle = cyc;
                stub_res = core_model(blockIN, enc_dec);
                dat_dly  = 5;
            end
            if (readData) nread_cnt++;
            if (err) begin
                err_cnt++;
                err_cycle = cyc;
            end
            if (out_valid) ov_cnt++;
            checks++;
            assert (!(in_ready && out_valid)) else begin
                errors++;
                $error("FAIL link_excl: in_ready=%0b out_valid=%0b, required not both 1", in_ready, out_valid);
            end
            checks++;
            assert ((int'(newKey) + int'(newData) + int'(readData)) <= 1) else begin
                errors++;
                $error("FAIL strobe_excl: newKey=%0b newData=%0b readData=%0b, required at most one", newKey, newData, readData);
            end
        end
    end

    // ---------------- scoreboard ----------------
    always @(negedge clk) begin : sb
        logic [7:0] e;
        if (nR && out_valid && out_ready) begin
            out_cnt++;
            e = 8'hxx;
            if (exp_q.size() > 0) e = exp_q.pop_front();
            checks++;
            assert (out_byte === e) else begin
                errors++;
                $error("FAIL out_byte: got %02h expected %02h", out_byte, e);
            end
        end
    end

    task automatic check(input string tag, input logic [95:0] obs, input logic [95:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // ---------------- drivers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n;
        n = 0;
        in_byte  = b;
        in_valid = 1'b1;
        while (!in_ready && n < 100) begin
            tick();
            n++;
        end
        checks++;
        assert (in_ready) else begin
            errors++;
            $error("FAIL send_byte: in_ready %0b after %0d cycles, required 1", in_ready, n);
        end
        tick();
        in_valid = 1'b0;
    endtask

    task automatic send_key(input logic [95:0] k);
        send_byte(8'h01);
        for (int i = 11; i >= 0; i--) send_byte(k[i*8 +: 8]);
    endtask

    task automatic send_block(input logic [7:0] op, input logic [47:0] v);
        send_byte(op);
        for (int i = 5; i >= 0; i--) send_byte(v[i*8 +: 8]);
    endtask

    task automatic push_expected(input logic [47:0] v);
        for (int i = 5; i >= 0; i--) exp_q.push_back(v[i*8 +: 8]);
    endtask

    task automatic wait_idle(input string tag, input int limit);
        int n;
        n = 0;
        while (busy && n < limit) begin
            tick();
            n++;
        end
        checks++;
        assert (!busy) else begin
            errors++;
            $error("FAIL %s: busy still %0b after %0d cycles, required 0", tag, busy, n);
        end
    endtask

    // ---------------- directed sequence ----------------
    initial begin : main
        int k0, d0, r0, e0, o0, c0;
        nR        = 1'b0;
        in_byte   = 8'h00;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        loadKey   = 1'b1;
        loadData  = 1'b1;

        repeat (3) tick();
        check("rst_in_ready",  in_ready,  0);
        check("rst_out_valid", out_valid, 0);
        check("rst_busy",      busy,      0);
        check("rst_key_ok",    key_ok,    0);
        check("rst_err",       err,       0);
        check("rst_enc_dec",   enc_dec,   1);
        check("rst_KEY",       KEY,       0);
        check("rst_blockIN",   blockIN,   0);
        check("rst_strobes",   {newKey, newData, readData}, 0);
        nR = 1'b1;
        tick();

        // Abort a key frame after 5 payload bytes.
        send_byte(8'h01);
        for (int i = 11; i >= 7; i--) send_byte(KEY_V[i*8 +: 8]);
        check("t1_busy_mid", busy, 1);
        nR = 1'b0;
        tick();
        check("t1_in_ready_rst", in_ready, 0);
        check("t1_busy_rst",     busy,     0);
        check("t1_KEY_rst",      KEY,      0);
        nR = 1'b1;
        tick();

        // Key load.
        k0 = nkey_cnt;
        send_key(KEY_V);
        wait_idle("t2_idle", 100);
        check("t2_newKey_cnt", nkey_cnt - k0, 1);
        check("t2_KEY",        KEY,           KEY_V);
        check("t2_key_ok",     key_ok,        1);

        // Encrypt.
        d0 = ndata_cnt; r0 = nread_cnt; c0 = out_cnt;
        push_expected(CT_V);
        send_block(8'h02, PT_V);
        wait_idle("t3_idle", 100);
        check("t3_enc_dec",   enc_dec,           1);
        check("t3_newData",   ndata_cnt - d0,    1);
        check("t3_readData",  nread_cnt - r0,    1);
        check("t3_out_cnt",   out_cnt - c0,      6);
        check("t3_q_empty",   exp_q.size(),      0);
        check("t3_blockIN",   blockIN,           PT_V);

        // Decrypt.
        d0 = ndata_cnt; r0 = nread_cnt; c0 = out_cnt;
        push_expected(PT_V);
        send_block(8'h03, CT_V);
        wait_idle("t4_idle", 100);
        check("t4_enc_dec",   enc_dec,           0);
        check("t4_newData",   ndata_cnt - d0,    1);
        check("t4_readData",  nread_cnt - r0,    1);
        check("t4_out_cnt",   out_cnt - c0,      6);
        check("t4_q_empty",   exp_q.size(),      0);

        // Output back-pressure: first byte must hold.
        out_ready = 1'b0;
        push_expected(CT_V);
        send_block(8'h02, PT_V);
        c0 = 0;
        while (!out_valid && c0 < 100) begin
            tick();
            c0++;
        end
        check("t6_out_valid_up", out_valid, 1);
        repeat (20) begin
            tick();
            check("t6_stall_byte",  out_byte,  8'h6e);
            check("t6_stall_valid", out_valid, 1);
        end
        out_ready = 1'b1;
        wait_idle("t6_drain", 100);
        check("t6_q_empty", exp_q.size(), 0);

        // Core never returns data: timeout.
        stub_hang = 1'b1;
        e0 = err_cnt; r0 = nread_cnt; o0 = ov_cnt;
        send_block(8'h02, PT_V);
        wait_idle("t6_tmo_idle", 400);
        tick();
        check("t6_tmo_err_cnt", err_cnt - e0,         1);
        check("t6_tmo_latency", err_cycle - nd_cycle, 256);
        check("t6_tmo_key_ok",  key_ok,               1);
        check("t6_tmo_readData", nread_cnt - r0,      0);
        check("t6_tmo_no_out",  ov_cnt - o0,          0);
        stub_hang = 1'b0;
        repeat (10) tick();

        // No key after reset, then an unknown opcode.
        nR = 1'b0;
        tick();
        nR = 1'b1;
        tick();
        check("t5_key_ok", key_ok, 0);
        e0 = err_cnt; d0 = ndata_cnt; o0 = ov_cnt;
        send_block(8'h02, PT_V);
        repeat (5) tick();
        check("t5_err_cnt",   err_cnt - e0,   1);
        check("t5_no_newData", ndata_cnt - d0, 0);
        check("t5_no_out",    ov_cnt - o0,    0);
        check("t5_busy",      busy,           0);
        e0 = err_cnt;
        send_byte(8'h7f);
        repeat (3) tick();
        check("t5_badop_err", err_cnt - e0, 1);
        check("t5_badop_busy", busy,        0);
        check("t5_badop_rdy",  in_ready,    1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
